ctrl_fsm: RTL

Multi-cycle control unit that drives the processor datapath. It takes the 16-bit instruction and ALU flags, sequences fetch/decode/execute/memory/write-back, and asserts every register enable, mux select and ALU opcode the datapath consumes. It also owns the processor status flags (PSR), the branch-condition evaluation, and the data-memory request handshake.

---
 rtl/ctrl_fsm.sv | 314 +++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/ctrl_fsm.sv
// ctrl_fsm: multi-cycle control unit sequencing fetch/decode/exec/mem/write-back for the 16-bit datapath.
// Optional feature: define CTRL_ILLEGAL_TRAP_EN to halt on undefined instructions (default: run them as NOP).
module ctrl_fsm (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] instruction,
    input  logic        C,
    input  logic        L,
    input  logic        F,
    input  logic        Z,
    input  logic        N,
    input  logic        memReady,
    output logic        irEn,
    output logic        pcRegEn,
    output logic        srcRegEn,
    output logic        dstRegEn,
    output logic        immRegEn,
    output logic        resultRegEn,
    output logic        regFileEn,
    output logic        signEn,
    output logic        pcRegMuxEn,
    output logic [1:0]  mux4En,
    output logic        regImmMuxEn,
    output logic        shiftALUMuxEn,
    output logic [3:0]  aluControl,
    output logic        memRead,
    output logic        memWrite,
    output logic        halted
);

    localparam logic [3:0] OP_AND = 4'b0001;
    localparam logic [3:0] OP_OR  = 4'b0010;
    localparam logic [3:0] OP_XOR = 4'b0011;
    localparam logic [3:0] OP_ADD = 4'b0101;
    localparam logic [3:0] OP_SUB = 4'b1001;
    localparam logic [3:0] OP_CMP = 4'b1011;
    localparam logic [3:0] OP_MOV = 4'b1101;

    localparam logic [3:0] OPC_REG   = 4'b0000;
    localparam logic [3:0] OPC_MEM   = 4'b0100;
    localparam logic [3:0] OPC_SHIFT = 4'b1000;
    localparam logic [3:0] OPC_BCOND = 4'b1100;

    localparam logic [3:0] EXT_LOAD  = 4'b0000;
    localparam logic [3:0] EXT_STOR  = 4'b0100;
    localparam logic [3:0] EXT_JCOND = 4'b1100;
    localparam logic [3:0] EXT_LSH   = 4'b0100;

    localparam logic [1:0] B_REG  = 2'd0;
    localparam logic [1:0] B_SIGN = 2'd1;
    localparam logic [1:0] B_ONE  = 2'd2;
    localparam logic [1:0] B_ZERO = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
    } state_t;

    typedef enum logic [2:0] {
        K_LOGIC, K_ARITH, K_CMP, K_SHIFT, K_BRANCH, K_LOAD, K_STOR, K_ILLEGAL
    } kind_t;

    typedef struct packed {
        logic       ir_en;
        logic       pc_reg_en;
        logic       src_reg_en;
        logic       dst_reg_en;
        logic       imm_reg_en;
        logic       result_reg_en;
        logic       reg_file_en;
        logic       sign_en;
        logic       pc_reg_mux_en;
        logic [1:0] mux4_en;
        logic       reg_imm_mux_en;
        logic       shift_alu_mux_en;
        logic [3:0] alu_control;
        logic       mem_read;
        logic       mem_write;
    } ctrl_t;

    state_t state_reg;
    kind_t  kind_reg;
    ctrl_t  ctrl_reg;
    logic   psr_c_reg, psr_l_reg, psr_f_reg, psr_z_reg, psr_n_reg;

    kind_t  dec_kind;
    ctrl_t  exec_ctrl;
    logic   taken;

    wire [3:0] opcode = instruction[15:12];
    wire [3:0] cond   = instruction[11:8];
    wire [3:0] ext    = instruction[7:4];

    // Rsrc is steered by the datapath directly; L is latched for software visibility only.
    logic unused_bits;
    assign unused_bits = ^{instruction[3:0], psr_l_reg};

    function automatic logic is_alu_op(input logic [3:0] op);
        return (op == OP_AND) || (op == OP_OR) || (op == OP_XOR) || (op == OP_ADD) ||
               (op == OP_SUB) || (op == OP_CMP) || (op == OP_MOV);
    endfunction

    function automatic kind_t alu_kind(input logic [3:0] op);
        if (op == OP_CMP)
            return K_CMP;
        else if ((op == OP_ADD) || (op == OP_SUB))
            return K_ARITH;
        else
            return K_LOGIC;
    endfunction

    function automatic ctrl_t alu_ctrl(input logic [3:0] op, input logic use_imm);
        ctrl_t c;
        c               = '0;
        c.pc_reg_mux_en = 1'b1;
        c.mux4_en       = use_imm ? B_SIGN : B_REG;
        c.sign_en       = use_imm;
        c.alu_control   = op;
        c.result_reg_en = (op != OP_CMP);
        return c;
    endfunction

    function automatic ctrl_t fetch_ctrl();
        ctrl_t c;
        c             = '0;
        c.ir_en       = 1'b1;
        c.pc_reg_en   = 1'b1;
        c.mux4_en     = B_ONE;
        c.alu_control = OP_ADD;
        return c;
    endfunction

    // Branches test the latched PSR so a flag change in the branch's own EXEC cannot affect it.
    always_comb begin
        case (cond)
            4'b0000: taken = psr_z_reg;
            4'b0001: taken = ~psr_z_reg;
            4'b0010: taken = psr_c_reg;
            4'b0011: taken = ~psr_c_reg;
            4'b0110: taken = psr_n_reg;
            4'b0111: taken = ~psr_n_reg;
            4'b1110: taken = 1'b1;
            default: taken = 1'b0;
        endcase
    end

    always_comb begin
        dec_kind  = K_ILLEGAL;
        exec_ctrl = '0;
        case (opcode)
            OPC_REG: begin
                if (is_alu_op(ext)) begin
                    dec_kind  = alu_kind(ext);
                    exec_ctrl = alu_ctrl(ext, 1'b0);
                end
            end
            OPC_SHIFT: begin
                if ((ext == EXT_LSH) || (ext[3:1] == 3'b000)) begin
                    dec_kind                   = K_SHIFT;
                    exec_ctrl.pc_reg_mux_en    = 1'b1;
                    exec_ctrl.shift_alu_mux_en = 1'b1;
                    exec_ctrl.reg_imm_mux_en   = (ext != EXT_LSH);
                    exec_ctrl.result_reg_en    = 1'b1;
                    exec_ctrl.alu_control      = ext;
                end
            end
            OPC_MEM: begin
                if (ext == EXT_LOAD) begin
                    dec_kind = K_LOAD;
                end else if (ext == EXT_STOR) begin
                    dec_kind = K_STOR;
                end else if (ext == EXT_JCOND) begin
                    // Target = Rsrc on the A port plus constant 0.
                    dec_kind                = K_BRANCH;
                    exec_ctrl.pc_reg_mux_en = 1'b1;
                    exec_ctrl.mux4_en       = B_ZERO;
                    exec_ctrl.alu_control   = OP_ADD;
                    exec_ctrl.pc_reg_en     = taken;
                end
            end
            OPC_BCOND: begin
                dec_kind              = K_BRANCH;
                exec_ctrl.mux4_en     = B_SIGN;
                exec_ctrl.sign_en     = 1'b1;
                exec_ctrl.alu_control = OP_ADD;
                exec_ctrl.pc_reg_en   = taken;
            end
            default: begin
                if (is_alu_op(opcode)) begin
                    dec_kind  = alu_kind(opcode);
                    exec_ctrl = alu_ctrl(opcode, 1'b1);
                end
            end
        endcase
    end

`ifdef CTRL_ILLEGAL_TRAP_EN
    logic halted_reg;
`endif

    // Outputs are registered: each transition loads the control word of the state being entered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= S_IDLE;
            kind_reg  <= K_ILLEGAL;
            ctrl_reg  <= '0;
            psr_c_reg <= 1'b0;
            psr_l_reg <= 1'b0;
            psr_f_reg <= 1'b0;
            psr_z_reg <= 1'b0;
            psr_n_reg <= 1'b0;
`ifdef CTRL_ILLEGAL_TRAP_EN
            halted_reg <= 1'b0;
`endif
        end else begin
            ctrl_reg <= '0;
            case (state_reg)
                S_IDLE, S_WB: begin
                    state_reg <= S_FETCH;
                    ctrl_reg  <= fetch_ctrl();
                end
                S_FETCH: begin
                    state_reg           <= S_DECODE;
                    ctrl_reg.src_reg_en <= 1'b1;
                    ctrl_reg.dst_reg_en <= 1'b1;
                    ctrl_reg.imm_reg_en <= 1'b1;
                end
                S_DECODE: begin
                    kind_reg <= dec_kind;
                    case (dec_kind)
                        K_LOAD: begin
                            state_reg         <= S_MEM;
                            ctrl_reg.mem_read <= 1'b1;
                        end
                        K_STOR: begin
                            state_reg          <= S_MEM;
                            ctrl_reg.mem_write <= 1'b1;
                        end
                        K_ILLEGAL: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
                            state_reg  <= S_HALT;
                            halted_reg <= 1'b1;
`else
                            state_reg <= S_FETCH;
                            ctrl_reg  <= fetch_ctrl();
`endif
                        end
                        default: begin
                            state_reg <= S_EXEC;
                            ctrl_reg  <= exec_ctrl;
                        end
                    endcase
                end
                S_EXEC: begin
                    if (kind_reg == K_CMP) begin
                        {psr_c_reg, psr_l_reg, psr_f_reg, psr_z_reg, psr_n_reg} <= {C, L, F, Z, N};
                    end else if (kind_reg == K_ARITH) begin
                        psr_c_reg <= C;
                        psr_f_reg <= F;
                    end
                    if ((kind_reg == K_LOGIC) || (kind_reg == K_ARITH) || (kind_reg == K_SHIFT)) begin
                        state_reg            <= S_WB;
                        ctrl_reg.reg_file_en <= 1'b1;
                    end else begin
                        state_reg <= S_FETCH;
                        ctrl_reg  <= fetch_ctrl();
                    end
                end
                S_MEM: begin
                    if (memReady) begin
                        if (kind_reg == K_LOAD) begin
                            state_reg            <= S_WB;
                            ctrl_reg.reg_file_en <= 1'b1;
                        end else begin
                            state_reg <= S_FETCH;
                            ctrl_reg  <= fetch_ctrl();
                        end
                    end else begin
                        ctrl_reg <= ctrl_reg;
                    end
                end
                S_HALT: begin
                    state_reg <= S_HALT;
                end
                default: begin
                    state_reg <= S_FETCH;
                    ctrl_reg  <= fetch_ctrl();
                end
            endcase
        end
    end

    assign irEn          = ctrl_reg.ir_en;
    assign pcRegEn       = ctrl_reg.pc_reg_en;
    assign srcRegEn      = ctrl_reg.src_reg_en;
    assign dstRegEn      = ctrl_reg.dst_reg_en;
    assign immRegEn      = ctrl_reg.imm_reg_en;
    assign resultRegEn   = ctrl_reg.result_reg_en;
    assign regFileEn     = ctrl_reg.reg_file_en;
    assign signEn        = ctrl_reg.sign_en;
    assign pcRegMuxEn    = ctrl_reg.pc_reg_mux_en;
    assign mux4En        = ctrl_reg.mux4_en;
    assign regImmMuxEn   = ctrl_reg.reg_imm_mux_en;
    assign shiftALUMuxEn = ctrl_reg.shift_alu_mux_en;
    assign aluControl    = ctrl_reg.alu_control;
    assign memRead       = ctrl_reg.mem_read;
    assign memWrite      = ctrl_reg.mem_write;

`ifdef CTRL_ILLEGAL_TRAP_EN
    assign halted = halted_reg;
`else
    assign halted = 1'b0;
`endif

endmodule
